// File: rtl/sa_cache_ctrl.sv
// N-way set-associative write-back / write-allocate cache controller with tree pseudo-LRU
// replacement, a line-wide memory port and first-lookup hit/miss counters.
module sa_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 128,
    parameter int SETS   = 64,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_rw,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [WORD_W-1:0] cpu_req_wdata,
    output logic              cpu_res_valid,
    output logic [WORD_W-1:0] cpu_res_rdata,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_res_ready,
    input  logic [LINE_W-1:0] mem_res_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int OFF_W   = $clog2(LINE_W / 8);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
    localparam int WPL     = LINE_W / WORD_W;
    localparam int WSEL_W  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int BSEL_W  = $clog2(WORD_W / 8);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W  = (WAYS > 1) ? WAYS - 1 : 1;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] COMPARE    = 2'd1;
    localparam logic [1:0] WRITE_BACK = 2'd2;
    localparam logic [1:0] ALLOCATE   = 2'd3;

    logic [1:0]        state_reg;
    logic              req_rw_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [WORD_W-1:0] req_wdata_reg;
    logic              first_lookup_reg;
    logic [WAY_W-1:0]  victim_reg;
    logic              mem_req_valid_reg;
    logic              mem_req_rw_reg;
    logic [ADDR_W-1:0] mem_req_addr_reg;
    logic [LINE_W-1:0] mem_req_wdata_reg;
    logic [31:0]       hit_count_reg;
    logic [31:0]       miss_count_reg;

    logic [WAYS-1:0]   valid_reg [SETS];
    logic [WAYS-1:0]   dirty_reg [SETS];
    logic [PLRU_W-1:0] plru_reg  [SETS];
    logic [TAG_W-1:0]  tag_reg   [SETS][WAYS];

    // A fill is written on the same edge the re-lookup read is issued, so the
    // freshly filled line is forwarded for that one COMPARE cycle.
    logic              byp_valid_reg;
    logic [WAY_W-1:0]  byp_way_reg;
    logic [LINE_W-1:0] byp_line_reg;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [INDEX_W-1:0] rd_index;
    logic [WSEL_W-1:0]  req_word;
    logic               unused_low_bits;

    assign req_tag         = req_addr_reg[ADDR_W-1 -: TAG_W];
    assign req_index       = req_addr_reg[OFF_W +: INDEX_W];
    assign rd_index        = (state_reg == IDLE) ? cpu_req_addr[OFF_W +: INDEX_W] : req_index;
    assign unused_low_bits = ^req_addr_reg[BSEL_W-1:0];

    generate
        if (WPL > 1) begin : g_wsel
            assign req_word = req_addr_reg[BSEL_W +: WSEL_W];
        end else begin : g_wsel_single
            assign req_word = '0;
        end
    endgenerate

    logic [WAYS-1:0]   hit_vec;
    logic [WAYS-1:0]   data_we;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] line_data [WAYS];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [LINE_W-1:0] data_mem [SETS];
            logic [LINE_W-1:0] rd_line_reg;

            always_ff @(posedge clk) begin
                if (data_we[gi])
                    data_mem[req_index] <= wr_line;
                rd_line_reg <= data_mem[rd_index];
            end

            assign hit_vec[gi]   = valid_reg[req_index][gi] && (tag_reg[req_index][gi] == req_tag);
            assign line_data[gi] = (byp_valid_reg && byp_way_reg == WAY_W'(gi)) ? byp_line_reg : rd_line_reg;
        end
    endgenerate

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              victim_dirty;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] merged_line;
    logic [WORD_W-1:0] rd_word;
    logic [2:0]        plru_cur;
    logic [2:0]        plru_upd;
    logic [1:0]        tree_victim;
    logic [1:0]        hw;
    logic [PLRU_W-1:0] plru_next;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit_line    = line_data[hit_way];
        rd_word     = hit_line[int'(req_word) * WORD_W +: WORD_W];
        merged_line = hit_line;
        merged_line[int'(req_word) * WORD_W +: WORD_W] = req_wdata_reg;

        // Tree bits point toward the least recently used side of each node.
        plru_cur    = 3'(plru_reg[req_index]);
        tree_victim = 2'b00;
        if (WAYS == 2)
            tree_victim = {1'b0, plru_cur[0]};
        else if (WAYS == 4)
            tree_victim = {plru_cur[0], plru_cur[0] ? plru_cur[2] : plru_cur[1]};
        victim = WAY_W'(tree_victim);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[req_index][w])
                victim = WAY_W'(w);
        end
        victim_dirty = valid_reg[req_index][victim] && dirty_reg[req_index][victim];

        hw       = 2'(hit_way);
        plru_upd = plru_cur;
        if (WAYS == 2) begin
            plru_upd[0] = ~hw[0];
        end else if (WAYS == 4) begin
            plru_upd[0] = ~hw[1];
            if (hw[1])
                plru_upd[2] = ~hw[0];
            else
                plru_upd[1] = ~hw[0];
        end
        plru_next = PLRU_W'(plru_upd);

        data_we = '0;
        wr_line = merged_line;
        if (!rst) begin
            if (state_reg == COMPARE && hit && req_rw_reg) begin
                data_we[hit_way] = 1'b1;
            end else if (state_reg == ALLOCATE && mem_res_ready) begin
                data_we[victim_reg] = 1'b1;
                wr_line             = mem_res_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_reg == ALLOCATE && mem_res_ready)
            tag_reg[req_index][victim_reg] <= req_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            first_lookup_reg  <= 1'b0;
            mem_req_valid_reg <= 1'b0;
            mem_req_rw_reg    <= 1'b0;
            hit_count_reg     <= '0;
            miss_count_reg    <= '0;
            byp_valid_reg     <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                plru_reg[s]  <= '0;
            end
        end else begin
            byp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_rw_reg       <= cpu_req_rw;
                        req_addr_reg     <= cpu_req_addr;
                        req_wdata_reg    <= cpu_req_wdata;
                        first_lookup_reg <= 1'b1;
                        state_reg        <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        state_reg           <= IDLE;
                        plru_reg[req_index] <= plru_next;
                        if (first_lookup_reg)
                            hit_count_reg <= hit_count_reg + 32'd1;
                        if (req_rw_reg)
                            dirty_reg[req_index][hit_way] <= 1'b1;
                    end else begin
                        if (first_lookup_reg)
                            miss_count_reg <= miss_count_reg + 32'd1;
                        first_lookup_reg  <= 1'b0;
                        victim_reg        <= victim;
                        mem_req_valid_reg <= 1'b1;
                        if (victim_dirty) begin
                            mem_req_rw_reg    <= 1'b1;
                            mem_req_addr_reg  <= {tag_reg[req_index][victim], req_index, {OFF_W{1'b0}}};
                            mem_req_wdata_reg <= line_data[victim];
                            state_reg         <= WRITE_BACK;
                        end else begin
                            mem_req_rw_reg   <= 1'b0;
                            mem_req_addr_reg <= {req_tag, req_index, {OFF_W{1'b0}}};
                            state_reg        <= ALLOCATE;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (mem_res_ready) begin
                        dirty_reg[req_index][victim_reg] <= 1'b0;
                        mem_req_rw_reg   <= 1'b0;
                        mem_req_addr_reg <= {req_tag, req_index, {OFF_W{1'b0}}};
                        state_reg        <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_res_ready) begin
                        mem_req_valid_reg                <= 1'b0;
                        valid_reg[req_index][victim_reg] <= 1'b1;
                        dirty_reg[req_index][victim_reg] <= 1'b0;
                        byp_valid_reg                    <= 1'b1;
                        byp_way_reg                      <= victim_reg;
                        byp_line_reg                     <= mem_res_rdata;
                        state_reg                        <= COMPARE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cpu_req_ready = (state_reg == IDLE);
    assign cpu_res_valid = (state_reg == COMPARE) && hit;
    assign cpu_res_rdata = req_rw_reg ? req_wdata_reg : rd_word;
    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req_rw    = mem_req_rw_reg;
    assign mem_req_addr  = mem_req_addr_reg;
    assign mem_req_wdata = mem_req_wdata_reg;
    assign hit_count     = hit_count_reg;
    assign miss_count    = miss_count_reg;
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Self-checking bench for sa_cache_ctrl (defaults: 2 ways, 64 sets, 16-byte lines) using a
// transaction-level cache model with true LRU and a delayed memory responder.
module tb_sa_cache_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_ready;
    logic         cpu_req_rw = 1'b0;
    logic [31:0]  cpu_req_addr = '0;
    logic [31:0]  cpu_req_wdata = '0;
    logic         cpu_res_valid;
    logic [31:0]  cpu_res_rdata;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_res_ready = 1'b0;
    logic [127:0] mem_res_rdata = '0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sa_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_rw(cpu_req_rw),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_res_valid(cpu_res_valid), .cpu_res_rdata(cpu_res_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_res_ready(mem_res_ready), .mem_res_rdata(mem_res_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // ---------------- memory side ----------------
    logic [127:0] mem_store [logic [31:0]];
    logic [127:0] ref_mem   [logic [31:0]];
    bit           mem_auto = 1'b0;
    int           mem_delay = 0;
    int           unstable = 0;
    bit           q_rw[$];
    logic [31:0]  q_addr[$];
    logic [127:0] q_wdata[$];

    function automatic logic [127:0] init_line(input logic [31:0] a);
        return {a ^ 32'h0F0F_0003, a ^ 32'h0F0F_0002, a ^ 32'h0F0F_0001, a ^ 32'h0F0F_0000};
    endfunction

    initial begin
        bit           c_rw;
        logic [31:0]  c_addr;
        logic [127:0] c_wdata;
        forever begin
            @(negedge clk);
            if (mem_auto && mem_req_valid === 1'b1 && !rst) begin
                c_rw = mem_req_rw; c_addr = mem_req_addr; c_wdata = mem_req_wdata;
                q_rw.push_back(c_rw); q_addr.push_back(c_addr); q_wdata.push_back(c_wdata);
                for (int k = 0; k < mem_delay; k++) begin
                    @(negedge clk);
                    if (mem_req_valid !== 1'b1 || mem_req_rw !== c_rw || mem_req_addr !== c_addr ||
                        (c_rw && mem_req_wdata !== c_wdata))
                        unstable++;
                end
                mem_res_ready = 1'b1;
                if (c_rw) begin
                    mem_res_rdata     = '0;
                    mem_store[c_addr] = c_wdata;
                end else begin
                    mem_res_rdata = mem_store.exists(c_addr) ? mem_store[c_addr] : init_line(c_addr);
                end
                @(negedge clk);
                mem_res_ready = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    bit           m_valid [64][2];
    bit           m_dirty [64][2];
    logic [21:0]  m_tag   [64][2];
    logic [127:0] m_data  [64][2];
    int           m_lru   [64];
    int           m_hits;
    int           m_misses;
    logic [31:0]  last_rdata;

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_req(input bit rw, input logic [31:0] addr, input logic [31:0] wdata, input string nm);
        int           idx, ws, way, exp_n, lat;
        logic [21:0]  tg;
        bit           exp_hit, got;
        bit           e_rw [2];
        logic [31:0]  e_addr [2];
        logic [127:0] e_wdata [2];
        logic [31:0]  exp_rdata;
        logic [31:0]  la;

        idx = int'(addr[9:4]); ws = int'(addr[3:2]); tg = addr[31:10];
        way = -1; exp_n = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tg) way = w;
        exp_hit = (way >= 0);
        if (exp_hit) begin
            m_hits++;
        end else begin
            m_misses++;
            way = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : m_lru[idx]);
            if (m_valid[idx][way] && m_dirty[idx][way]) begin
                e_rw[exp_n]    = 1'b1;
                e_addr[exp_n]  = {m_tag[idx][way], addr[9:4], 4'h0};
                e_wdata[exp_n] = m_data[idx][way];
                ref_mem[e_addr[exp_n]] = m_data[idx][way];
                exp_n++;
            end
            la = {addr[31:4], 4'h0};
            e_rw[exp_n] = 1'b0; e_addr[exp_n] = la; e_wdata[exp_n] = '0;
            exp_n++;
            m_data[idx][way]  = ref_mem.exists(la) ? ref_mem[la] : init_line(la);
            m_tag[idx][way]   = tg;
            m_valid[idx][way] = 1'b1;
            m_dirty[idx][way] = 1'b0;
        end
        if (rw) begin
            m_data[idx][way][ws*32 +: 32] = wdata;
            m_dirty[idx][way] = 1'b1;
            exp_rdata = wdata;
        end else begin
            exp_rdata = m_data[idx][way][ws*32 +: 32];
        end
        m_lru[idx] = 1 - way;

        q_rw.delete(); q_addr.delete(); q_wdata.delete();
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_wdata = wdata;
        checks++;
        if (cpu_req_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready: got %b expected 1", nm, cpu_req_ready);
        end
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (cpu_res_valid === 1'b1) begin
                got = 1'b1;
                last_rdata = cpu_res_rdata;
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s response: got none within %0d cycles expected one", nm, lat);
        end
        if (exp_hit) begin
            checks++;
            if (lat != 1) begin
                errors++; $display("FAIL %s hit_latency: got %0d expected 1", nm, lat);
            end
        end
        checks++;
        if (last_rdata !== exp_rdata) begin
            errors++; $display("FAIL %s rdata @%h: got %h expected %h", nm, addr, last_rdata, exp_rdata);
        end
        @(negedge clk);
        checks++;
        if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin
            errors++;
            $display("FAIL %s counters: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     nm, hit_count, miss_count, m_hits, m_misses);
        end
        checks++;
        if (q_addr.size() != exp_n) begin
            errors++; $display("FAIL %s mem_count: got %0d expected %0d", nm, q_addr.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < q_addr.size(); i++) begin
            checks++;
            if (q_rw[i] !== e_rw[i] || q_addr[i] !== e_addr[i] || (e_rw[i] && q_wdata[i] !== e_wdata[i])) begin
                errors++;
                $display("FAIL %s mem_req%0d: got rw=%b addr=%h wdata=%h expected rw=%b addr=%h wdata=%h",
                         nm, i, q_rw[i], q_addr[i], q_wdata[i], e_rw[i], e_addr[i], e_wdata[i]);
            end
        end
        $display("txn %s rw=%b addr=%h wdata=%h rdata=%h hit=%b mem_reqs=%0d", nm, rw, addr, wdata,
                 last_rdata, exp_hit, q_addr.size());
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (cpu_req_ready !== 1'b1 || cpu_res_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_rw !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b res_valid=%b mem_valid=%b mem_rw=%b expected 1 0 0 0",
                     cpu_req_ready, cpu_res_valid, mem_req_valid, mem_req_rw);
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", hit_count, miss_count);
        end
    endtask

    task automatic test_cold_read();
        logic [127:0] pl;
        pl = {32'h1111_0003, 32'h1111_0002, 32'hA5A5_0001, 32'h1111_0000};
        mem_store[32'h1000] = pl;
        ref_mem[32'h1000]   = pl;
        mem_auto = 1'b1; mem_delay = 2;
        do_req(1'b0, 32'h1000, 32'h0, "cold_read");
        do_req(1'b0, 32'h1004, 32'h0, "warm_read");
        checks++;
        if (last_rdata !== 32'hA5A5_0001 || hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL cold_read_fixed: got rdata=%h hit=%0d miss=%0d expected a5a50001 1 1",
                     last_rdata, hit_count, miss_count);
        end
    endtask

    task automatic test_write_hit();
        do_req(1'b1, 32'h1008, 32'hDEAD_BEEF, "write_hit");
        do_req(1'b0, 32'h1008, 32'h0, "read_after_write");
        checks++;
        if (last_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_hit_fixed: got %h expected deadbeef", last_rdata);
        end
    endtask

    task automatic test_conflict();
        logic [127:0] wb;
        do_req(1'b0, 32'h2000, 32'h0, "conflict_fill");
        do_req(1'b0, 32'h2000, 32'h0, "conflict_hit");
        do_req(1'b0, 32'h3000, 32'h0, "conflict_evict");
        wb = (q_wdata.size() > 0) ? q_wdata[0] : '0;
        checks++;
        if (q_addr.size() < 2 || q_addr[0] !== 32'h1000 || wb[95:64] !== 32'hDEAD_BEEF || q_addr[1] !== 32'h3000) begin
            errors++;
            $display("FAIL conflict_fixed: got n=%0d wb_word2=%h expected wb 1000 word2 deadbeef then fill 3000",
                     q_addr.size(), wb[95:64]);
        end
        do_req(1'b0, 32'h2000, 32'h0, "conflict_survivor");
    endtask

    task automatic test_write_miss();
        do_req(1'b1, 32'h4010, 32'h1234_5678, "write_miss");
        checks++;
        if (last_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL write_miss_fixed: got %h expected 12345678", last_rdata);
        end
        do_req(1'b0, 32'h5010, 32'h0, "wm_fill2");
        do_req(1'b0, 32'h6010, 32'h0, "wm_evict");
        do_req(1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, "max_addr_write");
        do_req(1'b0, 32'hFFFF_FFFC, 32'h0, "max_addr_read");
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        apply_reset();
        mem_auto = 1'b0;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h1000;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (mem_req_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || mem_req_rw !== 1'b0 || mem_req_addr !== 32'h1000) begin
            errors++;
            $display("FAIL rst_mid_fill_req: got valid=%b rw=%b addr=%h expected 1 0 00001000",
                     seen, mem_req_rw, mem_req_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || cpu_req_ready !== 1'b1 || cpu_res_valid !== 1'b0 ||
            hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_state: got mem_valid=%b ready=%b res=%b hit=%0d miss=%0d expected 0 1 0 0 0",
                     mem_req_valid, cpu_req_ready, cpu_res_valid, hit_count, miss_count);
        end
        mem_res_ready = 1'b1;
        mem_res_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        mem_res_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || cpu_req_ready !== 1'b1 || cpu_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_ready: got mem_valid=%b ready=%b res=%b expected 0 1 0",
                     mem_req_valid, cpu_req_ready, cpu_res_valid);
        end
        model_reset();
        mem_auto = 1'b1; mem_delay = 1;
        do_req(1'b0, 32'h1000, 32'h0, "rst_reread");
        checks++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++; $display("FAIL rst_reread_counters: got %0d/%0d expected 0/1", hit_count, miss_count);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        mem_delay = 1;
        do_req(1'b1, 32'h0000_0050, 32'h0BAD_0001, "stall_a");
        do_req(1'b1, 32'h0000_0454, 32'h0BAD_0002, "stall_b");
        mem_delay = 20;
        unstable = 0;
        fork
            do_req(1'b0, 32'h0000_0858, 32'h0, "stall_evict");
            begin
                bit wb_seen;
                wb_seen = 1'b0;
                for (int k = 0; k < 50 && !wb_seen; k++) begin
                    @(negedge clk);
                    if (mem_req_valid === 1'b1 && mem_req_rw === 1'b1) wb_seen = 1'b1;
                end
                checks++;
                if (!wb_seen) begin
                    errors++; $display("FAIL stall_wb_seen: got none expected write-back");
                end
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (cpu_req_ready !== 1'b0) begin
                        errors++; $display("FAIL stall_ready: got %b expected 0", cpu_req_ready);
                    end
                    cpu_req_valid = 1'b1; cpu_req_rw = 1'b1; cpu_req_addr = $urandom; cpu_req_wdata = $urandom;
                end
                @(negedge clk);
                cpu_req_valid = 1'b0;
            end
        join
        checks++;
        if (unstable != 0) begin
            errors++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", unstable);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 200; n++) begin
            mem_delay = int'($urandom_range(0, 3));
            a = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 2)) << 4) | (32'($urandom_range(0, 3)) << 2);
            do_req(1'($urandom_range(0, 1)), a, $urandom, $sformatf("rand%0d", n));
            if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cold_read();
        test_write_hit();
        test_conflict();
        test_write_miss();
        test_reset_mid_op();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
